// File: rtl/pmod_btn_reader.sv
// Four-button PMOD front end: synchroniser, prescaled debouncer, press/release pulses,
// and a 7-bit up/down/clear counter with a hold mode for the LED PMOD.
module pmod_btn_reader #(
  parameter int PRESCALE   = 12000,
  parameter int DB_COUNT   = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] btn_raw_i,
  output logic [3:0] btn_state_o,
  output logic [3:0] btn_press_o,
  output logic [3:0] btn_release_o,
  output logic [6:0] value_o,
  output logic       hold_o,
  output logic       wrap_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_COUNT - 1);

  logic [3:0]    cond;
  logic [3:0]    sync1_q, sync2_q;
  logic [PW-1:0] ps_q, ps_d;
  logic          tick;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];
  logic [3:0]    state_q, state_d;
  logic [3:0]    press_q, press_d;
  logic [3:0]    release_q, release_d;
  logic [6:0]    value_q, value_d;
  logic          hold_q, hold_d;
  logic          wrap_q, wrap_d;

  assign cond = (ACTIVE_LOW != 0) ? ~btn_raw_i : btn_raw_i;
  assign tick = (ps_q == PS_LAST);
  assign ps_d = tick ? '0 : ps_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == state_q[i]) begin
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          state_d[i]   = sync2_q[i];
          db_cnt_d[i]  = '0;
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Up/down decisions look at the hold level from before this press took effect.
  always_comb begin
    value_d = value_q;
    hold_d  = press_q[3] ? ~hold_q : hold_q;
    wrap_d  = 1'b0;
    if (press_q[2]) begin
      value_d = '0;
    end else if (!hold_q && (press_q[0] != press_q[1])) begin
      if (press_q[0]) begin
        value_d = value_q + 7'd1;
        wrap_d  = (value_q == 7'd127);
      end else begin
        value_d = value_q - 7'd1;
        wrap_d  = (value_q == 7'd0);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      ps_q      <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      value_q   <= '0;
      hold_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      sync1_q   <= cond;
      sync2_q   <= sync1_q;
      ps_q      <= ps_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      value_q   <= value_d;
      hold_q    <= hold_d;
      wrap_q    <= wrap_d;
    end
  end

  assign btn_state_o   = state_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;
  assign value_o       = value_q;
  assign hold_o        = hold_q;
  assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_pmod_btn_reader.sv
// Scoreboard bench for pmod_btn_reader: a tick-level reference model predicts debounce
// events and counter results; a negedge monitor pops and compares them.
module tb_pmod_btn_reader;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] btn_raw_i = 4'd0;
  logic [3:0] btn_state_o, btn_press_o, btn_release_o;
  logic [6:0] value_o;
  logic       hold_o, wrap_o;

  pmod_btn_reader #(.PRESCALE(4), .DB_COUNT(3), .ACTIVE_LOW(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .btn_raw_i(btn_raw_i),
    .btn_state_o(btn_state_o), .btn_press_o(btn_press_o), .btn_release_o(btn_release_o),
    .value_o(value_o), .hold_o(hold_o), .wrap_o(wrap_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] pr;
    logic [3:0] rl;
    int         val;
    logic       hold;
    logic       wr;
  } exp_t;

  exp_t       expq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         wrap_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button level flips once the last three tick samples
  // (raw delayed two cycles, one tick every fourth edge) all disagree with it.
  int         k;
  logic [3:0] rawq[$];
  logic [3:0] sw[$];
  logic [3:0] mstate;
  int         mvalue;
  logic       mhold;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k = 0;
      rawq.delete();
      sw.delete();
      expq.delete();
      mstate = 4'd0;
      mvalue = 0;
      mhold  = 1'b0;
    end else begin
      k++;
      rawq.push_back(btn_raw_i);
      if (rawq.size() > 3) void'(rawq.pop_front());
      if (k % 4 == 0) begin
        logic [3:0] sample, pr, rl;
        exp_t e;
        logic nh, wr;
        sample = rawq[0];
        sw.push_back(sample);
        if (sw.size() > 3) void'(sw.pop_front());
        pr = 4'd0;
        rl = 4'd0;
        if (sw.size() == 3) begin
          for (int i = 0; i < 4; i++) begin
            if (sw[0][i] != mstate[i] && sw[1][i] != mstate[i] && sw[2][i] != mstate[i]) begin
              mstate[i] = sample[i];
              if (sample[i]) pr[i] = 1'b1;
              else rl[i] = 1'b1;
            end
          end
        end
        if ((pr | rl) != 4'd0) begin
          wr = 1'b0;
          nh = pr[3] ? ~mhold : mhold;
          if (pr[2]) mvalue = 0;
          else if (!mhold && pr[0] != pr[1]) begin
            if (pr[0]) begin
              wr = (mvalue == 127);
              mvalue = (mvalue + 1) % 128;
            end else begin
              wr = (mvalue == 0);
              mvalue = (mvalue + 127) % 128;
            end
          end
          mhold = nh;
          e.pr = pr; e.rl = rl; e.val = mvalue; e.hold = mhold; e.wr = wr;
          expq.push_back(e);
        end
      end
    end
  end

  exp_t pend_item;
  logic pend = 1'b0;

  always @(negedge clk_i) begin
    if (rst_i) begin
      pend = 1'b0;
      check("reset_outputs",
            int'({btn_state_o, btn_press_o, btn_release_o, value_o, hold_o, wrap_o}), 0);
    end else begin
      if (wrap_o) wrap_cnt++;
      if (pend) begin
        check("value", int'(value_o), pend_item.val);
        check("hold", int'(hold_o), int'(pend_item.hold));
        check("wrap", int'(wrap_o), int'(pend_item.wr));
        pend = 1'b0;
      end else begin
        check("wrap_idle", int'(wrap_o), 0);
      end
      if ((btn_press_o | btn_release_o) != 4'd0) begin
        if (expq.size() == 0) begin
          check("unexpected_event", int'({btn_press_o, btn_release_o}), 0);
        end else begin
          pend_item = expq.pop_front();
          check("press", int'(btn_press_o), int'(pend_item.pr));
          check("release", int'(btn_release_o), int'(pend_item.rl));
          pend = 1'b1;
        end
      end
      check("state", int'(btn_state_o), int'(mstate));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic tap(input int b);
    btn_raw_i[b] = 1'b1;
    cyc(24);
    btn_raw_i[b] = 1'b0;
    cyc(24);
  endtask

  initial begin
    int lat;
    cyc(5);
    rst_i = 1'b0;
    cyc(100);
    check("idle_value", int'(value_o), 0);
    check("idle_hold", int'(hold_o), 0);

    btn_raw_i[0] = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk_i);
      lat++;
      if (btn_press_o[0]) break;
    end
    check("press_latency_in_window", int'(lat >= 10 && lat <= 16), 1);
    cyc(30);
    btn_raw_i[0] = 1'b0;
    cyc(30);
    check("first_up", int'(value_o), 1);

    for (int i = 0; i < 4; i++) begin
      btn_raw_i[0] = (i % 2 == 0);
      cyc(5);
    end
    btn_raw_i[0] = 1'b1;
    cyc(30);
    btn_raw_i[0] = 1'b0;
    cyc(30);
    check("bounce_single_inc", int'(value_o), 2);

    tap(2);
    check("cleared", int'(value_o), 0);
    wrap_cnt = 0;
    tap(1);
    check("dec_wrap_value", int'(value_o), 127);
    check("dec_wrap_count", wrap_cnt, 1);
    wrap_cnt = 0;
    for (int i = 0; i < 128; i++) tap(0);
    check("up128_value", int'(value_o), 127);
    check("up128_wraps", wrap_cnt, 1);

    tap(3);
    check("hold_on", int'(hold_o), 1);
    tap(0);
    tap(0);
    check("hold_blocks_up", int'(value_o), 127);
    tap(2);
    check("clear_in_hold", int'(value_o), 0);
    check("hold_kept", int'(hold_o), 1);
    tap(3);
    check("hold_off", int'(hold_o), 0);

    btn_raw_i[1] = 1'b1;
    cyc(8);
    rst_i = 1'b1;
    cyc(3);
    rst_i = 1'b0;
    cyc(40);
    btn_raw_i[1] = 1'b0;
    cyc(30);
    check("post_reset_dec", int'(value_o), 127);

    for (int i = 0; i < 300; i++) begin
      btn_raw_i = 4'($urandom_range(0, 15));
      cyc(int'($urandom_range(1, 30)));
    end
    btn_raw_i = 4'd0;
    cyc(40);
    check("queue_drained", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
